// File: rtl/fsm_input_conditioner.sv
// Input front end for the gated FSM counter: synchronises and debounces the raw
// board inputs, turns each debounced button press into a one-cycle step pulse.

module fsm_input_conditioner_debounce #(
    parameter int             W               = 1,
    parameter int             DEBOUNCE_CYCLES = 4,
    parameter logic [W-1:0]   IDLE            = '0
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [W-1:0] i_raw,
    output logic [W-1:0] o_stable
);
    localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0]  r_sync1;
    logic [W-1:0]  r_sync2;
    logic [W-1:0]  r_stable;
    logic [CW-1:0] r_cnt;

    // r_sync1 holds the value r_sync2 takes next, so a mismatch means the
    // candidate is changing and the count restarts. The word is compared as
    // a whole, so a skewed multi-bit change never commits a half-updated code.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1  <= IDLE;
            r_sync2  <= IDLE;
            r_stable <= IDLE;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if ((r_sync2 == r_stable) || (r_sync2 != r_sync1)) begin
                r_cnt <= '0;
            end else if (r_cnt == TERM) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable = r_stable;
endmodule

module fsm_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk_1hz,
    input  logic       reset,
    input  logic       mode_switch_raw,
    input  logic       step_button_raw,
    input  logic [1:0] fsm_input_x_raw,
    output logic [1:0] fsm_input_x,
    output logic       run_mode,
    output logic       step_pulse,
    output logic       fsm_enable
);
    logic       w_mode_stable;
    logic       w_step_stable;
    logic [1:0] w_x_stable;
    logic       r_step_prev;
    logic       r_step_pulse;

    fsm_input_conditioner_debounce #(
        .W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE(1'b1)
    ) u_mode_db (
        .i_clk    (clk_1hz),
        .i_reset  (reset),
        .i_raw    (mode_switch_raw),
        .o_stable (w_mode_stable)
    );

    fsm_input_conditioner_debounce #(
        .W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE(1'b1)
    ) u_step_db (
        .i_clk    (clk_1hz),
        .i_reset  (reset),
        .i_raw    (step_button_raw),
        .o_stable (w_step_stable)
    );

    fsm_input_conditioner_debounce #(
        .W(2), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .IDLE(2'b00)
    ) u_x_db (
        .i_clk    (clk_1hz),
        .i_reset  (reset),
        .i_raw    (fsm_input_x_raw),
        .o_stable (w_x_stable)
    );

    // Button is active-low: a press is the debounced level falling 1->0.
    // Prev resets to released so a button held through reset yields a fresh press.
    always_ff @(posedge clk_1hz) begin
        if (reset) begin
            r_step_prev  <= 1'b1;
            r_step_pulse <= 1'b0;
        end else begin
            r_step_prev  <= w_step_stable;
            r_step_pulse <= r_step_prev & ~w_step_stable;
        end
    end

    assign fsm_input_x = w_x_stable;
    assign run_mode    = w_mode_stable;
    assign step_pulse  = r_step_pulse;
    assign fsm_enable  = w_mode_stable | r_step_pulse;
endmodule

// File: tb/tb_fsm_input_conditioner.sv
// Directed bench for fsm_input_conditioner with DEBOUNCE_CYCLES=4: reset values,
// debounce latency, glitch rejection, step pulse generation and mode interplay.

module tb_fsm_input_conditioner;
    logic       clk_1hz = 1'b0;
    logic       reset;
    logic       mode_switch_raw;
    logic       step_button_raw;
    logic [1:0] fsm_input_x_raw;
    logic [1:0] fsm_input_x;
    logic       run_mode;
    logic       step_pulse;
    logic       fsm_enable;

    int checks = 0;
    int errors = 0;
    int pulse_cnt;

    fsm_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk_1hz         (clk_1hz),
        .reset           (reset),
        .mode_switch_raw (mode_switch_raw),
        .step_button_raw (step_button_raw),
        .fsm_input_x_raw (fsm_input_x_raw),
        .fsm_input_x     (fsm_input_x),
        .run_mode        (run_mode),
        .step_pulse      (step_pulse),
        .fsm_enable      (fsm_enable)
    );

    always #5 clk_1hz = ~clk_1hz;

    // Advance one rising edge and settle past it before sampling or driving.
    task automatic tick();
        @(posedge clk_1hz);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    initial begin
        // 1: reset with arbitrary raw inputs
        reset           = 1'b1;
        mode_switch_raw = 1'b0;
        step_button_raw = 1'b0;
        fsm_input_x_raw = 2'b11;
        tick();
        chk1("t1_run_mode_r1", run_mode, 1'b1);
        tick();
        tick();
        chk1("t1_run_mode", run_mode, 1'b1);
        chk2("t1_x", fsm_input_x, 2'b00);
        chk1("t1_pulse", step_pulse, 1'b0);
        chk1("t1_enable", fsm_enable, 1'b1);
        reset           = 1'b0;
        mode_switch_raw = 1'b1;
        step_button_raw = 1'b1;
        fsm_input_x_raw = 2'b00;
        for (int i = 0; i < 8; i++) tick();
        chk1("t1_idle_run", run_mode, 1'b1);
        chk1("t1_idle_pulse", step_pulse, 1'b0);
        chk2("t1_idle_x", fsm_input_x, 2'b00);

        // 2: clean x changes, a short glitch, and a skewed two-bit change
        fsm_input_x_raw = 2'b01;
        for (int i = 0; i < 5; i++) tick();
        chk2("t2_x_edge5", fsm_input_x, 2'b00);
        tick();
        chk2("t2_x_edge6", fsm_input_x, 2'b01);
        fsm_input_x_raw = 2'b10;
        for (int i = 0; i < 5; i++) tick();
        chk2("t2_x2_edge5", fsm_input_x, 2'b01);
        tick();
        chk2("t2_x2_edge6", fsm_input_x, 2'b10);
        fsm_input_x_raw = 2'b11;
        for (int i = 0; i < 3; i++) tick();
        fsm_input_x_raw = 2'b10;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk2("t2_glitch", fsm_input_x, 2'b10);
        end
        fsm_input_x_raw = 2'b11;
        tick();
        chk2("t2_skew_e1", fsm_input_x, 2'b10);
        fsm_input_x_raw = 2'b01;
        for (int i = 2; i <= 6; i++) begin
            tick();
            chk2("t2_skew_hold", fsm_input_x, 2'b10);
        end
        tick();
        chk2("t2_skew_e7", fsm_input_x, 2'b01);

        // 3: bouncing button then held: one pulse 7 edges after settling
        for (int i = 0; i < 10; i++) begin
            step_button_raw = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            chk1("t3_bounce", step_pulse, 1'b0);
        end
        step_button_raw = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk1("t3_pre", step_pulse, 1'b0);
        end
        tick();
        chk1("t3_pulse_e7", step_pulse, 1'b1);
        chk1("t3_enable_e7", fsm_enable, 1'b1);
        pulse_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (step_pulse) pulse_cnt++;
        end
        chk2("t3_held_extra", 2'(pulse_cnt), 2'd0);
        step_button_raw = 1'b1;
        pulse_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (step_pulse) pulse_cnt++;
        end
        chk2("t3_release", 2'(pulse_cnt), 2'd0);

        // 4: STEP mode, two presses of 8 cycles separated by 8-cycle releases
        mode_switch_raw = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk1("t4_mode_e5", run_mode, 1'b1);
        tick();
        chk1("t4_mode_e6", run_mode, 1'b0);
        chk1("t4_enable_e6", fsm_enable, 1'b0);
        pulse_cnt = 0;
        for (int t = 1; t <= 32; t++) begin
            step_button_raw = (((t - 1) % 16) < 8) ? 1'b0 : 1'b1;
            tick();
            chk1("t4_enable", fsm_enable, (t == 7) || (t == 23));
            if (fsm_enable) pulse_cnt++;
        end
        chk2("t4_pulse_count", 2'(pulse_cnt), 2'd2);

        // 5: button held across RUN->STEP gives no pulse until re-pressed
        mode_switch_raw = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk1("t5_run", run_mode, 1'b1);
        step_button_raw = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk1("t5_run_pulse", step_pulse, 1'b1);
        chk1("t5_run_enable", fsm_enable, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        mode_switch_raw = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk1("t5_step_mode", run_mode, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk1("t5_held", fsm_enable, 1'b0);
        end
        step_button_raw = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk1("t5_release", fsm_enable, 1'b0);
        end
        step_button_raw = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            chk1("t5_repress", fsm_enable, t == 7);
        end

        // 6: reset while the button is pressed, button still held afterwards
        step_button_raw = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        step_button_raw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("t6_pre", step_pulse, 1'b0);
        end
        reset = 1'b1;
        tick();
        chk1("t6_rst_pulse", step_pulse, 1'b0);
        chk1("t6_rst_run", run_mode, 1'b1);
        chk2("t6_rst_x", fsm_input_x, 2'b00);
        reset = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            tick();
            chk1("t6_post", step_pulse, 1'b0);
        end
        chk1("t6_run_e5", run_mode, 1'b1);
        chk2("t6_x_e5", fsm_input_x, 2'b00);
        tick();
        chk1("t6_pulse_e6", step_pulse, 1'b0);
        chk1("t6_run_e6", run_mode, 1'b0);
        chk2("t6_x_e6", fsm_input_x, 2'b01);
        tick();
        chk1("t6_pulse_e7", step_pulse, 1'b1);
        chk1("t6_enable_e7", fsm_enable, 1'b1);
        tick();
        chk1("t6_pulse_e8", step_pulse, 1'b0);
        chk1("t6_enable_e8", fsm_enable, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
